pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter and fetch sequencer for the 16-bit multicycle datapath. Fetches one 16-bit instruction word per issue from instruction memory over a req/ack handshake and holds it in the instruction register for decode. It consumes the 16-bit sign-extended 8-bit branch offset produced by the immediate sign-extension stage. On each instruction retire it computes the next PC: sequential, PC-relative branch, or absolute jump.

Parameters:
PC_W, 16, width of PC, memory address and branch offset
INSTR_W, 16, instruction word width
RESET_PC, 16'h0000, PC value loaded on reset
BR_SHIFT, 1, left shift applied to the branch offset (word-to-byte scaling)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held high until ack
imem_addr  output  PC_W  fetch address, equal to pc_out while imem_req is high
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  INSTR_W  fetched instruction word
ir_out  output  INSTR_W  instruction register
ir_valid  output  1  ir_out is valid and awaiting retire
ctl_done  input  1  control unit retires the current instruction
br_take  input  1  take the PC-relative branch at retire
br_offset  input  PC_W  sign-extended branch offset
jmp_en  input  1  take the absolute jump at retire
jmp_target  input  PC_W  absolute jump address
pc_out  output  PC_W  current PC
pc_plus2  output  PC_W  pc_out+2, registered at fetch, used for link and branch base
misalign  output  1  sticky misaligned-jump flag (see Optional Feature)

Behaviour:
- Reset, asynchronous and immediate: state=S_FETCH; pc_out=RESET_PC; pc_plus2=RESET_PC+2; ir_out=0; ir_valid=0; misalign=0. imem_req is combinational from state, so it is high in the first cycle after reset release.
- FSM states: S_FETCH, S_ISSUE, S_HALT. S_HALT exists only with the optional feature.
- S_FETCH: imem_req=1, imem_addr=pc_out, ir_valid=0.
  - On imem_ack: ir_out<=imem_rdata, pc_plus2<=pc_out+2, then go to S_ISSUE.
  - If imem_ack is low, remain in S_FETCH. There is no timeout.
- S_ISSUE: imem_req=0, ir_valid=1. Wait for ctl_done.
  - On ctl_done, pc_out is updated by priority:
    1. jmp_en: pc <= jmp_target with bit0 forced to 0.
    2. br_take: pc <= pc_plus2 + (br_offset << BR_SHIFT).
    3. Otherwise: pc <= pc_plus2.
  - Then go to S_FETCH.
- Latency: minimum 2 cycles per instruction (ack on the first S_FETCH cycle, ctl_done on the first S_ISSUE cycle).
- Arithmetic: all sums are modulo 2^PC_W and wrap silently. Example: pc 16'hFFFE, sequential → 16'h0000.
- The offset is treated as two's complement because it is already sign-extended. Range is -256..+254 bytes from pc_plus2.
- Ignored inputs: ctl_done, br_take and jmp_en are ignored in S_FETCH. imem_ack and imem_rdata are ignored in S_ISSUE.
- ir_out and pc_out are stable throughout S_ISSUE.
- Reset asserted mid-fetch or mid-issue: the outstanding request is abandoned and imem_req drops in the same instant. A late ack after reset release is taken as the ack for the fresh RESET_PC fetch. Memory must not ack an abandoned request.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: a retire with jmp_en=1 and jmp_target[0]=1 does not update pc.
  - misalign<=1; go to S_HALT.
  - S_HALT drives imem_req=0 and ir_valid=0, and stays there until rst_n.
  - pc_out holds the address of the faulting instruction.
- Undefined: bit0 is silently cleared, misalign is tied to 0, and S_HALT is not generated.

Decomposition:
- Package pc_seq_pkg: state encoding (S_FETCH, S_ISSUE, S_HALT), PC_W/INSTR_W defaults, PC_INC=2, RESET_PC default.
- One sub-module, branch_target_adder: combinational. Inputs pc_plus2, br_offset, jmp_target, br_take, jmp_en. Output next_pc with the priority mux. Instantiated once.

Test Plan:
- Reset then fetch: rst_n low→high. Expect imem_req=1, imem_addr=0000. Ack with 16'h1234 → ir_out=1234, ir_valid=1, pc_plus2=0002.
- Sequential: ctl_done with no branch at pc=0000 → next fetch addr 0002. Hold ack low for 5 cycles → imem_req stays 1 and addr is stable.
- Branch: pc=0010, br_take=1, br_offset=FFFC (-4) → next addr 0012-8=000A. br_offset=007F → 0012+00FE=0110.
- Jump priority and wrap: br_take=1 and jmp_en=1 with jmp_target=4000 → 4000. pc=FFFE sequential → 0000.
- Reset mid-operation: assert rst_n low in S_ISSUE at pc=0200 → immediately pc_out=0000, ir_valid=0, imem_req=0. After release, fetch from 0000.
- Align check: jmp_target=0101 → without the macro, addr 0100. With PC_ALIGN_CHECK_EN: misalign=1, imem_req stays 0, pc_out unchanged until reset.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch/PC sequencer: state encoding and default widths.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned PC_INC      = 2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Next-PC selection at retire: absolute jump over PC-relative branch over sequential.
module branch_target_adder #(
  parameter int PC_W     = 16,
  parameter int BR_SHIFT = 1
) (
  input  logic [PC_W-1:0] pc_plus2,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_take,
  input  logic            jmp_en,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] jmp_aligned;
  logic [PC_W-1:0] br_dest;

  // Offset is already sign-extended, so a plain modulo add gives the signed result.
  assign jmp_aligned = jmp_target & ~PC_W'(1);
  assign br_dest     = pc_plus2 + (br_offset << BR_SHIFT);

  always_comb begin
    next_pc = pc_plus2;
    if (jmp_en)       next_pc = jmp_aligned;
    else if (br_take) next_pc = br_dest;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction fetch sequencer (req/ack fetch, retire-driven PC update).
// Optional misaligned-jump halt is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              BR_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ctl_done,
  input  logic               br_take,
  input  logic [PC_W-1:0]    br_offset,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_target,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus2,
  output logic               misalign
);

  pc_state_e       state, state_nxt;
  logic [PC_W-1:0] next_pc;
  logic            fetch_done;
  logic            retire;
  logic            jmp_fault;

  branch_target_adder #(
    .PC_W     (PC_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_bta (
    .pc_plus2   (pc_plus2),
    .br_offset  (br_offset),
    .jmp_target (jmp_target),
    .br_take    (br_take),
    .jmp_en     (jmp_en),
    .next_pc    (next_pc)
  );

  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign retire     = (state == S_ISSUE) && ctl_done;

`ifdef PC_ALIGN_CHECK_EN
  assign jmp_fault = jmp_en && jmp_target[0];
`else
  assign jmp_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: if (imem_ack) state_nxt = S_ISSUE;
      S_ISSUE: if (ctl_done) state_nxt = jmp_fault ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Request is gated by rst_n so an outstanding fetch is dropped the instant reset asserts.
  always_comb begin
    imem_req  = (state == S_FETCH) && rst_n;
    ir_valid  = (state == S_ISSUE);
    imem_addr = pc_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out   <= RESET_PC;
      pc_plus2 <= RESET_PC + PC_W'(PC_INC);
      ir_out   <= '0;
    end else begin
      if (fetch_done) begin
        ir_out   <= imem_rdata;
        pc_plus2 <= pc_out + PC_W'(PC_INC);
      end
      if (retire && !jmp_fault) pc_out <= next_pc;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     misalign <= 1'b0;
    else if (retire && jmp_fault)   misalign <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations are hand-computed constants.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ctl_done;
  logic        br_take;
  logic [15:0] br_offset;
  logic        jmp_en;
  logic [15:0] jmp_target;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(
    .PC_W     (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000),
    .BR_SHIFT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .ctl_done   (ctl_done),
    .br_take    (br_take),
    .br_offset  (br_offset),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .pc_out     (pc_out),
    .pc_plus2   (pc_plus2),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic retire(input logic bt, input logic [15:0] off,
                        input logic je, input logic [15:0] tgt);
    ctl_done   = 1'b1;
    br_take    = bt;
    br_offset  = off;
    jmp_en     = je;
    jmp_target = tgt;
    tick();
    ctl_done   = 1'b0;
    br_take    = 1'b0;
    jmp_en     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ctl_done = 1'b0;
    br_take = 1'b0; br_offset = '0; jmp_en = 1'b0; jmp_target = '0;
    #13;
    chk("rst_pc",       32'(pc_out),   32'h0000);
    chk("rst_pc_plus2", 32'(pc_plus2), 32'h0002);
    chk("rst_ir",       32'(ir_out),   32'h0000);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_req",      32'(imem_req), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);

    @(negedge clk); rst_n = 1'b1; tick();
    chk("first_req",  32'(imem_req),  32'h1);
    chk("first_addr", 32'(imem_addr), 32'h0000);
    fetch(16'h1234);
    chk("ir_load",     32'(ir_out),   32'h1234);
    chk("ir_valid_hi", 32'(ir_valid), 32'h1);
    chk("plus2_load",  32'(pc_plus2), 32'h0002);
    chk("issue_req",   32'(imem_req), 32'h0);

    imem_ack = 1'b1; imem_rdata = 16'hDEAD; tick(); imem_ack = 1'b0;
    chk("issue_ignores_ack", 32'(ir_out), 32'h1234);
    chk("issue_still",       32'(ir_valid), 32'h1);

    retire(1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("seq_addr", 32'(imem_addr), 32'h0002);
    ctl_done = 1'b1; jmp_en = 1'b1; jmp_target = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req",  32'(imem_req),  32'h1);
      chk("stall_addr", 32'(imem_addr), 32'h0002);
    end
    ctl_done = 1'b0; jmp_en = 1'b0;

    fetch(16'h0001);
    retire(1'b0, 16'h0000, 1'b1, 16'h0010);
    chk("jmp_0010", 32'(imem_addr), 32'h0010);
    fetch(16'h0002);
    chk("plus2_0012", 32'(pc_plus2), 32'h0012);
    retire(1'b1, 16'hFFFC, 1'b0, 16'h0000);
    chk("br_neg", 32'(imem_addr), 32'h000A);

    fetch(16'h0003);
    retire(1'b0, 16'h0000, 1'b1, 16'h0010);
    fetch(16'h0004);
    retire(1'b1, 16'h007F, 1'b0, 16'h0000);
    chk("br_pos", 32'(imem_addr), 32'h0110);

    fetch(16'h0005);
    retire(1'b1, 16'h0004, 1'b1, 16'h4000);
    chk("jmp_priority", 32'(imem_addr), 32'h4000);
    fetch(16'h0006);
    retire(1'b0, 16'h0000, 1'b1, 16'hFFFE);
    fetch(16'h0007);
    chk("wrap_plus2", 32'(pc_plus2), 32'h0000);
    retire(1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("wrap_addr", 32'(imem_addr), 32'h0000);

    fetch(16'h0008);
    retire(1'b0, 16'h0000, 1'b1, 16'h0200);
    fetch(16'h0009);
    chk("pre_rst_pc",    32'(pc_out),   32'h0200);
    chk("pre_rst_valid", 32'(ir_valid), 32'h1);
    rst_n = 1'b0; #1;
    chk("mid_rst_pc",    32'(pc_out),   32'h0000);
    chk("mid_rst_valid", 32'(ir_valid), 32'h0);
    chk("mid_rst_req",   32'(imem_req), 32'h0);
    chk("mid_rst_ir",    32'(ir_out),   32'h0000);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_req",  32'(imem_req),  32'h1);
    chk("post_rst_addr", 32'(imem_addr), 32'h0000);

    fetch(16'h000A);
    retire(1'b0, 16'h0000, 1'b1, 16'h0101);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_misalign", 32'(misalign), 32'h1);
    chk("align_req",      32'(imem_req), 32'h0);
    chk("align_valid",    32'(ir_valid), 32'h0);
    chk("align_pc",       32'(pc_out),   32'h0000);
    imem_ack = 1'b1; ctl_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 1'b0; ctl_done = 1'b0;
    chk("halt_req",      32'(imem_req), 32'h0);
    chk("halt_pc",       32'(pc_out),   32'h0000);
    chk("halt_misalign", 32'(misalign), 32'h1);
`else
    chk("align_addr",     32'(imem_addr), 32'h0100);
    chk("align_req",      32'(imem_req),  32'h1);
    chk("align_misalign", 32'(misalign),  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
